// File: rtl/key_pkg.sv
// Shared definitions for the key debounce array: FSM state encodings,
// default 50 MHz timing constants and a counter-width helper.
package key_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  typedef logic [1:0] key_state_t;

  localparam int unsigned DEBOUNCE_CYC_50M = 250000;    // 5 ms
  localparam int unsigned LONG_CYC_50M     = 50000000;  // 1 s
  localparam int unsigned REPEAT_CYC_50M   = 10000000;  // 200 ms

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: input synchroniser, integrating debounce FSM, hold counter
// and event pulses. Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_50M,
  parameter int unsigned LONG_CYC     = LONG_CYC_50M,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_50M
) (
  input  logic Clk_50mhz,
  input  logic Rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [SYNC_N-1:0] sync_q;
  logic              pressed;

  key_state_t        state_q, state_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Sync chain resets to the released pin level so a held key is seen as a new press.
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) sync_q <= {SYNC_N{INV}};
    else        sync_q <= {sync_q[SYNC_N-2:0], key_i};
  end

  assign pressed = sync_q[SYNC_N-1] ^ INV;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_REL_CHK;
          cnt_d   = '0;
        end else begin
          if (hold_q == HOLD_LAST) long_d = 1'b1;
          if (hold_q != HOLD_SAT)  hold_d = hold_q + 1'b1;
        end
      end
      ST_REL_CHK: begin
        // Hold counter is frozen here and resumes on a bounce back to HELD.
        if (pressed) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_W = cnt_width(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             repeat_q, repeat_d;

  // Repeat phase starts on the key_long cycle and restarts whenever HELD is left.
  always_comb begin
    rep_d    = rep_q;
    repeat_d = 1'b0;
    if (state_q == ST_HELD) begin
      if (!pressed) begin
        rep_d = '0;
      end else if (hold_q == HOLD_LAST) begin
        rep_d = '0;
      end else if (hold_q == HOLD_SAT) begin
        if (rep_q == REP_LAST) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner; one key_debounce_chan per key.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_50M,
  parameter int unsigned LONG_CYC     = LONG_CYC_50M,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_50M
) (
  input  logic              Clk_50mhz,
  input  logic              Rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_chan (
      .Clk_50mhz(Clk_50mhz),
      .Rst_n    (Rst_n),
      .key_i    (key_in[gi]),
      .level_o  (key_level[gi]),
      .press_o  (key_press[gi]),
      .release_o(key_release[gi]),
      .long_o   (key_long[gi]),
      .repeat_o (key_repeat[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed, table-driven bench for key_debounce_array with short timing
// (DEBOUNCE_CYC=8, LONG_CYC=32, REPEAT_CYC=16, SYNC_STAGES=2, ACTIVE_LOW=1).
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] lvl, prs, rel, lng, rpt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #10 clk = ~clk;

  key_debounce_array #(
    .N_KEYS(4), .ACTIVE_LOW(1), .SYNC_STAGES(2),
    .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(16)
  ) dut (
    .Clk_50mhz  (clk),
    .Rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (lvl),
    .key_press  (prs),
    .key_release(rel),
    .key_long   (lng),
    .key_repeat (rpt)
  );

  typedef struct {
    logic [3:0] key;
    int         waitn;
    logic [3:0] e_lvl, e_prs, e_rel, e_lng, e_rpt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic evt(input int kind, input int ch);
    case (kind)
      0:       return prs[ch];
      1:       return rel[ch];
      default: return lng[ch];
    endcase
  endfunction

  // Counts falling edges until the event appears; returns maxc if it never does.
  task automatic wait_evt(input int kind, input int ch, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (evt(kind, ch)) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, long_cnt, long_at, rep_cnt, rep_at;
    logic rel_seen, lvl_drop;
    logic [4:0] ev;

    // Tests 1 and 4; each row: drive key, wait falling edges, compare outputs.
    vecs[0]  = '{4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'hE, 10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{4'hE, 1,  4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[3]  = '{4'hE, 1,  4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{4'hF, 10, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[5]  = '{4'hF, 1,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[6]  = '{4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{4'h0, 10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{4'h0, 1,  4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    vecs[9]  = '{4'h0, 1,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[10] = '{4'h1, 2,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[11] = '{4'h3, 3,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[12] = '{4'h7, 3,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{4'hF, 3,  4'hE, 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[14] = '{4'hF, 2,  4'hC, 4'h0, 4'h2, 4'h0, 4'h0};
    vecs[15] = '{4'hF, 3,  4'h8, 4'h0, 4'h4, 4'h0, 4'h0};
    vecs[16] = '{4'hF, 3,  4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    vecs[17] = '{4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {12'h0, lvl, prs, rel, lng, rpt}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      key_in = vecs[i].key;
      repeat (vecs[i].waitn) @(negedge clk);
      $display("vec %0d key_in=%h level=%h press=%h release=%h long=%h repeat=%h",
               i, key_in, lvl, prs, rel, lng, rpt);
      check($sformatf("vec%0d", i), {12'h0, lvl, prs, rel, lng, rpt},
            {12'h0, vecs[i].e_lvl, vecs[i].e_prs, vecs[i].e_rel, vecs[i].e_lng, vecs[i].e_rpt});
    end

    // Test 2: key 1 bouncing every 3 cycles must never be accepted.
    ev = '0;
    for (int k = 0; k < 72; k++) begin
      if (k < 60 && (k % 3) == 0) key_in[1] = ~key_in[1];
      if (k == 60) key_in[1] = 1'b1;
      @(negedge clk);
      ev |= {lvl[1], prs[1], rel[1], lng[1], rpt[1]};
    end
    $display("t2 bounce key1 events=%b", ev);
    check("t2_no_events", {27'h0, ev}, 32'h0);
    check("t2_level", {28'h0, lvl}, 32'h0);

    // Test 3: long press on key 2.
    key_in = 4'hB;
    wait_evt(0, 2, 40, n);
    check("t3_press_latency", n, 11);
    long_cnt = 0; long_at = 0; rep_cnt = 0; rep_at = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (lng[2]) begin long_cnt++; long_at = k; end
      if (rpt[2]) begin rep_cnt++; rep_at = k; end
    end
    $display("t3 long key2 long_cnt=%0d long_at=%0d rep_cnt=%0d rep_at=%0d",
             long_cnt, long_at, rep_cnt, rep_at);
    check("t3_long_count", long_cnt, 1);
    check("t3_long_at", long_at, 32);
`ifdef KEY_AUTOREPEAT_EN
    check("t3_repeat_count", rep_cnt, 1);
    check("t3_repeat_at", rep_at, 48);
`else
    check("t3_repeat_count", rep_cnt, 0);
`endif
    key_in = 4'hF;
    wait_evt(1, 2, 40, n);
    check("t3_release_latency", n, 11);
    repeat (2) @(negedge clk);

    // Test 5: reset pulse while key 3 is held.
    key_in = 4'h7;
    wait_evt(0, 3, 40, n);
    check("t5_press_latency", n, 11);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {12'h0, lvl, prs, rel, lng, rpt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rel_seen = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rel[3]) rel_seen = 1'b1;
      if (prs[3]) break;
    end
    $display("t5 reset pulse key3 re-press after %0d edges, release_seen=%b", n, rel_seen);
    check("t5_repress_latency", n, 11);
    check("t5_no_release", {31'h0, rel_seen}, 32'h0);
    key_in = 4'hF;
    wait_evt(1, 3, 40, n);
    check("t5_release_latency", n, 11);
    repeat (2) @(negedge clk);

    // Test 6: 5-cycle release glitch on key 0 while held.
    key_in = 4'hE;
    wait_evt(0, 0, 40, n);
    check("t6_press_latency", n, 11);
    c = 0; long_cnt = 0; long_at = 0; rel_seen = 1'b0; lvl_drop = 1'b0;
    repeat (4) begin @(negedge clk); c++; end
    key_in = 4'hF;
    repeat (5) begin @(negedge clk); c++; if (rel[0]) rel_seen = 1'b1; end
    key_in = 4'hE;
    while (c < 60) begin
      @(negedge clk);
      c++;
      if (rel[0]) rel_seen = 1'b1;
      if (!lvl[0]) lvl_drop = 1'b1;
      if (lng[0]) begin long_cnt++; long_at = c; end
    end
    $display("t6 glitch key0 long_cnt=%0d long_at=%0d release_seen=%b level_drop=%b",
             long_cnt, long_at, rel_seen, lvl_drop);
    check("t6_no_release", {31'h0, rel_seen}, 32'h0);
    check("t6_level_kept", {31'h0, lvl_drop}, 32'h0);
    check("t6_long_count", long_cnt, 1);
    // Hold count survives the glitch: long lands at +32, delayed at most by the glitch span.
    check("t6_long_window", {31'h0, (long_at >= 32 && long_at <= 38)}, 32'h1);
    key_in = 4'hF;
    wait_evt(1, 0, 40, n);
    check("t6_release_latency", n, 11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
